aux_bus_ram: RTL and testbench

- Parametrised aux-bus memory target for the risc16f84 aux port (aux_adr_o/aux_dat_io/aux_we_o/aux_re_o); successor to the flat combinational aux test RAM.
- Adds address-window decode, configurable read latency (0 = legacy combinational), a post-reset fill sequence, and a split data bus with output enable in place of an internal tristate.
- Instantiated in simulation tops and in FPGA builds as a scratch or peripheral RAM.

---
 rtl/aux_bus_pkg.sv | 13 +
 rtl/aux_rd_pipe.sv | 44 ++++
 rtl/aux_bus_ram.sv | 138 +++++++++++++
 tb/tb_aux_bus_ram.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_bus_pkg.sv
// Shared types and default widths for the aux-bus RAM target.
package aux_bus_pkg;

    localparam int unsigned AUX_DATA_WIDTH   = 8;
    localparam int unsigned AUX_ADDR_WIDTH   = 16;
    localparam int unsigned MAX_READ_LATENCY = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_e;

endpackage

// File: rtl/aux_rd_pipe.sv
// Read-return shift register: LATENCY stages of valid/data, LATENCY=0 is a wire.
// Each stage's data only loads alongside a valid, so the output holds between reads.
module aux_rd_pipe #(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] dat_o
);

    if (LATENCY == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign vld_o = vld_i;
        assign dat_o = dat_i;
    end else begin : g_pipe
        logic                  vld_q [LATENCY];
        logic [DATA_WIDTH-1:0] dat_q [LATENCY];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < LATENCY; i++) begin
                    vld_q[i] <= 1'b0;
                    dat_q[i] <= '0;
                end
            end else begin
                vld_q[0] <= vld_i;
                if (vld_i) dat_q[0] <= dat_i;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign vld_o = vld_q[LATENCY-1];
        assign dat_o = dat_q[LATENCY-1];
    end

endmodule

// File: rtl/aux_bus_ram.sv
// Windowed aux-bus RAM: post-reset fill, address decode, configurable read latency.
// Define AUX_BUS_RAM_WP_EN to enable the write-protect window (WP_BASE/WP_SIZE).
module aux_bus_ram
    import aux_bus_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = AUX_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH     = AUX_ADDR_WIDTH,
    parameter int unsigned           MEM_ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           READ_LATENCY   = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = '0,
    parameter int unsigned           WP_BASE        = 0,
    parameter int unsigned           WP_SIZE        = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] aux_adr_i,
    input  logic [DATA_WIDTH-1:0] aux_dat_i,
    input  logic                  aux_we_i,
    input  logic                  aux_re_i,
    output logic [DATA_WIDTH-1:0] aux_dat_o,
    output logic                  aux_oe_o,
    output logic                  rd_valid_o,
    output logic                  init_busy_o,
    output logic                  wp_err_o
);

    localparam int unsigned DEPTH = 32'(1) << MEM_ADDR_WIDTH;

    if (MEM_ADDR_WIDTH > ADDR_WIDTH || READ_LATENCY > MAX_READ_LATENCY
        || WP_BASE + WP_SIZE > DEPTH
        || (BASE_ADDR & ADDR_WIDTH'(DEPTH - 1)) != '0) begin : g_param_err
        $error("aux_bus_ram: illegal parameter combination");
    end

    ram_state_e                state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic [MEM_ADDR_WIDTH-1:0] offset;
    logic                      hit;
    logic                      wp_hit;
    logic                      wr_accept;
    logic                      rd_accept;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH-1:0]     rd_data_c;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    assign offset = aux_adr_i[MEM_ADDR_WIDTH-1:0];

    if (MEM_ADDR_WIDTH < ADDR_WIDTH) begin : g_hit
        assign hit = aux_adr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH]
                     == BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
    end else begin : g_hit_all
        assign hit = 1'b1;
    end

`ifdef AUX_BUS_RAM_WP_EN
    logic wp_err_q;

    assign wp_hit = (32'(offset) >= WP_BASE) && (32'(offset) < WP_BASE + WP_SIZE);

    // One-cycle error pulse following a blocked write.
    always_ff @(posedge clk) begin
        if (reset) wp_err_q <= 1'b0;
        else       wp_err_q <= wr_accept & wp_hit;
    end

    assign wp_err_o = wp_err_q;
`else
    assign wp_hit   = 1'b0;
    assign wp_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // Fill sequence, bus accept and memory write-port steering.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = offset;
        mem_wdata  = aux_dat_i;
        wr_accept  = 1'b0;
        rd_accept  = 1'b0;
        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = fill_cnt_q;
                mem_wdata  = FILL_VALUE;
                fill_cnt_d = fill_cnt_q + MEM_ADDR_WIDTH'(1);
                if (fill_cnt_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                wr_accept = aux_we_i & hit;
                rd_accept = aux_re_i & hit & ~aux_we_i;
                mem_we    = wr_accept & ~wp_hit;
            end
            default: state_d = ST_INIT;
        endcase
        // Nothing lands or issues while reset is held.
        if (reset) begin
            mem_we    = 1'b0;
            wr_accept = 1'b0;
            rd_accept = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign rd_data_c = mem[offset];

    aux_rd_pipe #(
        .LATENCY    (READ_LATENCY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk   (clk),
        .reset (reset),
        .vld_i (rd_accept),
        .dat_i (rd_data_c),
        .vld_o (rd_valid_o),
        .dat_o (aux_dat_o)
    );

    assign aux_oe_o    = rd_valid_o;
    assign init_busy_o = (state_q == ST_INIT);

endmodule

// File: tb/tb_aux_bus_ram.sv
// Bench for aux_bus_ram: latency-2 and latency-0 instances against a queue-based model.
module tb_aux_bus_ram;

    localparam int unsigned LAT  = 2;
    localparam logic [7:0]  FILL = 8'hA5;

    typedef struct {
        int         due;
        logic [7:0] d;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adr;
    logic [7:0]  din;
    logic        we, re;

    logic [7:0] dat2, dat0;
    logic       oe2, oe0, v2, v0, busy2, busy0, wp2, wp0;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state
    logic [7:0] m_mem [16];
    logic       m_run = 1'b0;
    int         m_cnt = 0;
    int         cyc   = 0;
    logic [7:0] m_last = 8'h00;
    logic       m_wp = 1'b0;
    bit         chk_en = 1'b0;
    rd_t        q[$];

    always #5 clk = ~clk;

    aux_bus_ram #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_ADDR_WIDTH(4), .BASE_ADDR(16'h0400),
        .READ_LATENCY(LAT), .FILL_VALUE(FILL), .WP_BASE(2), .WP_SIZE(2)
    ) dut (
        .clk(clk), .reset(reset), .aux_adr_i(adr), .aux_dat_i(din), .aux_we_i(we),
        .aux_re_i(re), .aux_dat_o(dat2), .aux_oe_o(oe2), .rd_valid_o(v2),
        .init_busy_o(busy2), .wp_err_o(wp2)
    );

    aux_bus_ram #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_ADDR_WIDTH(4), .BASE_ADDR(16'h0400),
        .READ_LATENCY(0), .FILL_VALUE(FILL), .WP_BASE(2), .WP_SIZE(2)
    ) dut0 (
        .clk(clk), .reset(reset), .aux_adr_i(adr), .aux_dat_i(din), .aux_we_i(we),
        .aux_re_i(re), .aux_dat_o(dat0), .aux_oe_o(oe0), .rd_valid_o(v0),
        .init_busy_o(busy0), .wp_err_o(wp0)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic logic m_hit(input logic [15:0] a);
        return a[15:4] == 12'h040;
    endfunction

    function automatic logic m_prot(input logic [3:0] off);
`ifdef AUX_BUS_RAM_WP_EN
        return off >= 4'd2 && off < 4'd4;
`else
        return 1'b0 && off[0];
`endif
    endfunction

    // Compare all outputs against the model for the current cycle.
    task automatic compare();
        logic       acc, ev;
        logic [7:0] ed;
        if (!chk_en) return;
        acc = m_run && !reset && re && !we && m_hit(adr);
        ev  = (q.size() > 0) && (q[0].due == cyc);
        ed  = ev ? q[0].d : m_last;
        check("busy",     32'(busy2), 32'(!m_run));
        check("busy0",    32'(busy0), 32'(!m_run));
        check("wp_err",   32'(wp2),   32'(m_wp));
        check("wp_err0",  32'(wp0),   32'(m_wp));
        check("rd_valid", 32'(v2),    32'(ev));
        check("oe",       32'(oe2),   32'(ev));
        check("dat",      32'(dat2),  32'(ed));
        check("rd_valid0", 32'(v0),   32'(acc));
        check("oe0",      32'(oe0),   32'(acc));
        if (acc) check("dat0", 32'(dat0), 32'(m_mem[adr[3:0]]));
    endtask

    // Advance the model across one clock edge.
    task automatic model_update();
        logic       wp_n;
        logic [3:0] off;
        wp_n = 1'b0;
        off  = adr[3:0];
        if (reset) begin
            m_run  = 1'b0;
            m_cnt  = 0;
            q.delete();
            m_last = 8'h00;
            m_wp   = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                m_last = q[0].d;
                void'(q.pop_front());
            end
            if (!m_run) begin
                m_mem[m_cnt] = FILL;
                if (m_cnt == 15) m_run = 1'b1;
                m_cnt = (m_cnt + 1) % 16;
            end else if (m_hit(adr)) begin
                if (we) begin
                    if (m_prot(off)) wp_n = 1'b1;
                    else             m_mem[off] = din;
                end else if (re) begin
                    q.push_back('{due: cyc + LAT, d: m_mem[off]});
                end
            end
            m_wp = wp_n;
        end
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (busy2 === 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        check(name, 32'(n), 32'd16);
    endtask

    initial begin
        logic [7:0] exp3, exp_wp, exp_pulse;
`ifdef AUX_BUS_RAM_WP_EN
        exp3 = FILL; exp_wp = FILL; exp_pulse = 8'd1;
`else
        exp3 = 8'h33; exp_wp = 8'hFF; exp_pulse = 8'd0;
`endif
        reset = 1'b1; adr = 16'h0; din = 8'h0; we = 1'b0; re = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        repeat (3) cycle();
        check("rst_busy", 32'(busy2), 32'd1);
        check("rst_valid", 32'(v2), 32'd0);
        check("rst_dat", 32'(dat2), 32'd0);
        reset = 1'b0;
        wait_init("init_len");

        // Every location reads back the fill value.
        for (int i = 0; i < 16; i++) begin
            adr = 16'h0400 + 16'(i); re = 1'b1;
            #1 check("fill_rd0", 32'(dat0), 32'(FILL));
            cycle();
        end
        re = 1'b0;
        repeat (3) cycle();

        // Write then read same offset the next cycle.
        adr = 16'h0405; din = 8'h3C; we = 1'b1; cycle();
        we = 1'b0; re = 1'b1; cycle();
        re = 1'b0;
        check("raw_early", 32'(v2), 32'd0);
        cycle();
        check("raw_valid", 32'(v2), 32'd1);
        check("raw_oe", 32'(oe2), 32'd1);
        check("raw_dat", 32'(dat2), 32'h3C);

        // Three back-to-back reads.
        for (int i = 0; i < 3; i++) begin
            adr = 16'h0400 + 16'(i); din = 8'h11 * 8'(i + 1); we = 1'b1; cycle();
        end
        we = 1'b0; re = 1'b1; adr = 16'h0400; cycle();
        adr = 16'h0401; cycle();
        check("b2b_0", 32'(dat2), 32'h11);
        adr = 16'h0402; cycle();
        check("b2b_1", 32'(dat2), 32'h22);
        re = 1'b0; cycle();
        check("b2b_2", 32'(dat2), 32'(exp3));
        check("b2b_v2", 32'(v2), 32'd1);
        cycle();
        check("b2b_end", 32'(v2), 32'd0);

        // Miss, then write/read collision.
        adr = 16'h0800; re = 1'b1;
        #1 check("miss_v0", 32'(v0), 32'd0);
        cycle(); re = 1'b0; cycle();
        check("miss_oe", 32'(oe2), 32'd0);
        adr = 16'h0401; din = 8'h5A; we = 1'b1; re = 1'b1; cycle();
        we = 1'b0; re = 1'b0; cycle(); cycle();
        check("coll_valid", 32'(v2), 32'd0);
        re = 1'b1; cycle(); re = 1'b0; cycle();
        check("coll_dat", 32'(dat2), 32'h5A);

        // Reset one cycle after a read flushes it.
        adr = 16'h0400; re = 1'b1; cycle();
        re = 1'b0; reset = 1'b1; cycle();
        reset = 1'b0;
        check("flush_valid", 32'(v2), 32'd0);
        // Reset at fill counter 7 restarts the fill.
        repeat (7) cycle();
        reset = 1'b1; cycle();
        reset = 1'b0;
        wait_init("refill_len");

        // Write protect on offset 3.
        adr = 16'h0403; din = 8'hFF; we = 1'b1; cycle();
        we = 1'b0;
        check("wp_pulse", 32'(wp2), 32'(exp_pulse));
        cycle();
        check("wp_once", 32'(wp2), 32'd0);
        re = 1'b1; cycle(); re = 1'b0; cycle();
        check("wp_data", 32'(dat2), 32'(exp_wp));

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            we    = ($urandom_range(0, 3) == 0);
            re    = $urandom_range(0, 1) == 1;
            adr   = 16'h03F8 + 16'($urandom_range(0, 31));
            din   = 8'($urandom);
            cycle();
        end
        reset = 1'b0; we = 1'b0; re = 1'b0;
        repeat (20) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
